// File: rtl/vram_pixel_writer_if.sv
// Host pixel-request and BRAM port-A signal bundle for vram_pixel_writer.
interface vram_pixel_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic                  i_valid;
  logic                  o_ready;
  logic [8:0]            i_x;
  logic [7:0]            i_y;
  logic [1:0]            i_op;
  logic                  i_clear;
  logic                  o_busy;
  logic                  o_error;
  logic                  o_vram_en;
  logic                  o_vram_we;
  logic [ADDR_WIDTH-1:0] o_vram_addr;
  logic [DATA_WIDTH-1:0] o_vram_wdata;
  logic [DATA_WIDTH-1:0] i_vram_rdata;

  modport slave (
    input  i_valid, i_x, i_y, i_op, i_clear, i_vram_rdata,
    output o_ready, o_busy, o_error, o_vram_en, o_vram_we, o_vram_addr, o_vram_wdata
  );

  modport master (
    output i_valid, i_x, i_y, i_op, i_clear, i_vram_rdata,
    input  o_ready, o_busy, o_error, o_vram_en, o_vram_we, o_vram_addr, o_vram_wdata
  );
endinterface

// File: rtl/vram_pixel_writer.sv
// Single-pixel set/clear/toggle as read-modify-write on 1-bpp VRAM port A.
// Optional whole-frame clear enabled by defining VRAM_PIXEL_WRITER_CLEAR_EN.
module vram_pixel_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int PIXEL_COLUMNS = 320,
    parameter int PIXEL_ROWS    = 240
) (
    input logic i_clk,
    input logic i_resetn,
    vram_pixel_writer_if.slave bus
);
    localparam int BIT_W              = $clog2(DATA_WIDTH);
    localparam int VRAM_ADDRESS_WIDTH = $clog2(PIXEL_COLUMNS*PIXEL_ROWS) - BIT_W;
    localparam int VRAM_DEPTH         = PIXEL_ROWS*PIXEL_COLUMNS/DATA_WIDTH;
    localparam int IDX_W              = VRAM_ADDRESS_WIDTH + BIT_W;
    localparam logic [8:0] X_LIM      = 9'(PIXEL_COLUMNS);
    localparam logic [7:0] Y_LIM      = 8'(PIXEL_ROWS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, CLEAR} state_t;

    state_t                        state;
    logic [VRAM_ADDRESS_WIDTH-1:0] addr_q;
    logic [BIT_W-1:0]              bit_q;
    logic [1:0]                    op_q;
    logic                          error_q;
    logic                          clear_pending;
    logic [VRAM_ADDRESS_WIDTH-1:0] clr_addr;
    logic [IDX_W-1:0]              idx;
    logic [DATA_WIDTH-1:0]         mask, modified;
    logic                          in_range;

    assign idx      = IDX_W'(bus.i_y) * IDX_W'(PIXEL_COLUMNS) + IDX_W'(bus.i_x);
    assign in_range = (bus.i_x < X_LIM) && (bus.i_y < Y_LIM);

`ifdef VRAM_PIXEL_WRITER_CLEAR_EN
    logic [VRAM_ADDRESS_WIDTH-1:0] clr_cnt;
    assign clr_addr = clr_cnt;
`else
    wire unused_clear = bus.i_clear;
    assign clear_pending = 1'b0;
    assign clr_addr      = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state   <= IDLE;
            error_q <= 1'b0;
`ifdef VRAM_PIXEL_WRITER_CLEAR_EN
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
`endif
        end else begin
            error_q <= 1'b0;
`ifdef VRAM_PIXEL_WRITER_CLEAR_EN
            // Pending is consumed on IDLE->CLEAR; a new pulse outside CLEAR re-arms it.
            clear_pending <= (clear_pending && state != IDLE) || (bus.i_clear && state != CLEAR);
`endif
            case (state)
                IDLE: begin
                    if (clear_pending) begin
                        state <= CLEAR;
                    end else if (bus.i_valid) begin
                        if (!in_range) begin
                            error_q <= 1'b1;
                        end else if (bus.i_op != 2'b11) begin
                            addr_q <= idx[IDX_W-1:BIT_W];
                            bit_q  <= BIT_W'(DATA_WIDTH-1) - idx[BIT_W-1:0];
                            op_q   <= bus.i_op;
                            state  <= READ;
                        end
                    end
                end
                READ:  state <= WRITE;
                WRITE: state <= IDLE;
`ifdef VRAM_PIXEL_WRITER_CLEAR_EN
                CLEAR: begin
                    if (clr_cnt == VRAM_ADDRESS_WIDTH'(VRAM_DEPTH-1)) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mask = DATA_WIDTH'(1) << bit_q;
        case (op_q)
            2'b00:   modified = bus.i_vram_rdata & ~mask;
            2'b01:   modified = bus.i_vram_rdata | mask;
            2'b10:   modified = bus.i_vram_rdata ^ mask;
            default: modified = bus.i_vram_rdata;
        endcase
    end

    // Gating with i_resetn keeps an aborted RMW or clear from writing in the reset cycle.
    assign bus.o_ready      = (state == IDLE) && !clear_pending && i_resetn;
    assign bus.o_busy       = (state != IDLE) && i_resetn;
    assign bus.o_error      = error_q;
    assign bus.o_vram_en    = (state != IDLE) && i_resetn;
    assign bus.o_vram_we    = (state == WRITE || state == CLEAR) && i_resetn;
    assign bus.o_vram_addr  = !i_resetn        ? '0 :
                              (state == CLEAR) ? clr_addr :
                              (state == IDLE)  ? '0 : addr_q;
    assign bus.o_vram_wdata = (state == WRITE && i_resetn) ? modified : '0;
endmodule

// File: tb/tb_vram_pixel_writer.sv
// Directed bench for vram_pixel_writer with a read-first BRAM model on port A.
module tb_vram_pixel_writer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0, xfers = 0, en_cnt = 0, zw_cnt = 0;
    int   xfer_cyc[$];
    logic [15:0] mem [0:4799];
    logic [15:0] rdata_q = '0;

    vram_pixel_writer_if bus ();

    vram_pixel_writer dut (.i_clk(clk), .i_resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    assign bus.i_vram_rdata = rdata_q;

    always @(posedge clk) begin
        cyc++;
        if (bus.i_valid && bus.o_ready) begin xfers++; xfer_cyc.push_back(cyc); end
        if (bus.o_vram_en) en_cnt++;
        if (bus.o_vram_en && bus.o_vram_we && bus.o_vram_wdata == 16'h0) zw_cnt++;
        if (bus.o_vram_en) begin
            rdata_q <= mem[bus.o_vram_addr];
            if (bus.o_vram_we) mem[bus.o_vram_addr] <= bus.o_vram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [1:0] op);
        @(negedge clk);
        bus.i_x = x; bus.i_y = y; bus.i_op = op; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic rmw(input string tag, input logic [12:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        chk({tag, "_rd_en"}, bus.o_vram_en, 1);
        chk({tag, "_rd_we"}, bus.o_vram_we, 0);
        chk({tag, "_rd_addr"}, bus.o_vram_addr, addr);
        chk({tag, "_rd_ready"}, bus.o_ready, 0);
        @(negedge clk);
        chk({tag, "_wr_we"}, bus.o_vram_we, 1);
        chk({tag, "_wr_addr"}, bus.o_vram_addr, addr);
        chk({tag, "_wr_data"}, bus.o_vram_wdata, wdata);
        @(negedge clk);
        chk({tag, "_ready"}, bus.o_ready, 1);
        chk({tag, "_idle_en"}, bus.o_vram_en, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e0, x0, n;
        for (int i = 0; i < 4800; i++) mem[i] = '0;
        bus.i_valid = 1'b1; bus.i_x = '0; bus.i_y = '0; bus.i_op = 2'b01; bus.i_clear = 1'b0;

        // reset held with a request presented: nothing accepted, all outputs quiet
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_en", bus.o_vram_en, 0);
        chk("rst_addr", bus.o_vram_addr, 0);
        chk("rst_wdata", bus.o_vram_wdata, 0);
        chk("rst_error", bus.o_error, 0);
        bus.i_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.o_ready, 1);
        chk("post_rst_xfers", xfers, 0);

        send(9'd0, 8'd0, 2'b01);    rmw("set00", 13'd0, 16'h8000);
        send(9'd17, 8'd0, 2'b01);   rmw("set17", 13'd1, 16'h4000);
        send(9'd16, 8'd0, 2'b01);   rmw("set16", 13'd1, 16'hC000);
        send(9'd319, 8'd239, 2'b10); rmw("tog1", 13'd4799, 16'h0001);
        send(9'd319, 8'd239, 2'b10); rmw("tog2", 13'd4799, 16'h0000);
        send(9'd17, 8'd0, 2'b00);   rmw("clr17", 13'd1, 16'h8000);

        // out-of-range x: one-cycle error, no VRAM access
        e0 = en_cnt;
        send(9'd320, 8'd0, 2'b01);
        @(negedge clk);
        chk("oor_error", bus.o_error, 1);
        chk("oor_ready", bus.o_ready, 1);
        @(negedge clk);
        chk("oor_error_drop", bus.o_error, 0);
        send(9'd0, 8'd240, 2'b01);
        @(negedge clk);
        chk("oor_y_error", bus.o_error, 1);
        send(9'd5, 8'd5, 2'b11);
        @(negedge clk);
        chk("nop_error", bus.o_error, 0);
        chk("nop_ready", bus.o_ready, 1);
        chk("oor_nop_en", en_cnt - e0, 0);

        // valid held high across four requests
        e0 = en_cnt; x0 = xfers; xfer_cyc.delete();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.i_x = 9'(40 + k); bus.i_y = 8'd5; bus.i_op = 2'b01; bus.i_valid = 1'b1;
            n = 0;
            while (!bus.o_ready && n < 10) begin @(negedge clk); n++; end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_xfers", xfers - x0, 4);
        chk("b2b_en", en_cnt - e0, 8);
        if (xfer_cyc.size() == 4) begin
            chk("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], 3);
            chk("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], 3);
            chk("b2b_gap3", xfer_cyc[3] - xfer_cyc[2], 3);
        end
        chk("b2b_mem", mem[102], 16'h00F0);

        // reset in READ drops the RMW
        send(9'd100, 8'd0, 2'b01);
        resetn = 1'b0;
        #1;
        chk("abort_en", bus.o_vram_en, 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_ready", bus.o_ready, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", bus.o_ready, 1);
        chk("abort_busy_after", bus.o_busy, 0);
        chk("abort_mem", mem[6], 16'h0000);

`ifdef VRAM_PIXEL_WRITER_CLEAR_EN
        // clear requested during the WRITE of a pixel op
        send(9'd1, 8'd0, 2'b01);
        @(posedge clk); #1;
        chk("clr_wr_data", bus.o_vram_wdata, 16'hC000);
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        chk("clr_entry_ready", bus.o_ready, 0);
        e0 = zw_cnt;
        @(posedge clk); #1;
        n = 0;
        while (bus.o_busy && n < 5000) begin @(negedge clk); n++; end
        chk("clr_count", zw_cnt - e0, 4800);
        chk("clr_mem0", mem[0], 16'h0);
        chk("clr_mem_last", mem[4799], 16'h0);
        chk("clr_ready", bus.o_ready, 1);

        // reset partway through a clear
        send(9'd319, 8'd239, 2'b01); rmw("pre_clr", 13'd4799, 16'h0001);
        @(negedge clk); bus.i_clear = 1'b1;
        @(negedge clk); bus.i_clear = 1'b0;
        n = 0;
        while (!(bus.o_vram_we && bus.o_vram_addr == 13'd100) && n < 300) begin @(negedge clk); n++; end
        chk("clr_reach_100", bus.o_vram_addr, 100);
        resetn = 1'b0;
        #1;
        chk("clr_abort_we", bus.o_vram_we, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("clr_abort_ready", bus.o_ready, 1);
        chk("clr_abort_busy", bus.o_busy, 0);
        chk("clr_abort_tail", mem[4799], 16'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_pixel_writer.md
# vram_pixel_writer

Host-side write port for the 320x240 1-bpp video RAM scanned out by the VGA display path. It accepts single-pixel set, clear and toggle requests over a valid/ready handshake and applies each one as a read-modify-write on the 16-bit VRAM word that holds the pixel. Bit ordering matches scan-out: MSB first. It drives port A of the dual-port BRAM while the display reads port B, and optionally performs a whole-frame clear.

## Interface
- DATA_WIDTH, 16, VRAM word width.
- PIXEL_COLUMNS, 320, framebuffer width in pixels.
- PIXEL_ROWS, 240, framebuffer height in pixels.
- Derived (localparam): VRAM_ADDRESS_WIDTH = $clog2(PIXEL_COLUMNS*PIXEL_ROWS) - $clog2(DATA_WIDTH) = 13; VRAM_DEPTH = PIXEL_ROWS*PIXEL_COLUMNS/DATA_WIDTH = 4800.

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  reset, synchronous, active-low.
- i_valid  in  1  pixel request valid.
- o_ready  out  1  writer can accept a request.
- i_x  in  9  pixel column.
- i_y  in  8  pixel row.
- i_op  in  2  operation: 00 clear, 01 set, 10 toggle, 11 no-op.
- i_clear  in  1  frame-clear request pulse.
- o_busy  out  1  state != IDLE.
- o_error  out  1  one-cycle pulse: accepted request was out of range.
- o_vram_en  out  1  BRAM port A enable.
- o_vram_we  out  1  BRAM port A write enable.
- o_vram_addr  out  13  BRAM port A word address.
- o_vram_wdata  out  16  BRAM port A write data.
- i_vram_rdata  in  16  BRAM port A read data, valid 1 cycle after an enabled read.

## Operation
- States: IDLE, READ, WRITE, CLEAR.
- Handshake: a transfer occurs when i_valid && o_ready at a rising edge. x, y and op are latched at that edge. o_ready = (state==IDLE) && !clear_pending && i_resetn. The request must be held stable until the transfer.
- Address: idx = y*PIXEL_COLUMNS + x, computed at 17 bits. Word address = idx[16:4]. Data bit = 15 - idx[3:0].
- Range check: if x >= 320 or y >= 240, the transfer completes, no VRAM access occurs, o_error pulses on the next cycle, and the state stays IDLE.
- op 11: the transfer completes with no VRAM access and no error.
- IDLE -> READ on a valid in-range transfer with op != 11.
- READ: en=1, we=0, addr = word address.
- WRITE: en=1, we=1, same addr. wdata = rdata with the target bit cleared (00), set (01) or inverted (10). All other bits pass through unchanged.
- WRITE -> IDLE unconditionally.
- VRAM control outputs derive only from registers. o_vram_wdata is combinational from i_vram_rdata during WRITE and 0 otherwise.
- Outputs in IDLE: en=0, we=0, addr=0, wdata=0.

## Timing
- Cycle 0: transfer. Cycle 1: READ. Cycle 2: WRITE. Cycle 3: o_ready=1.
- Sustained throughput: one pixel per 3 cycles.
- Reset (i_resetn low at an edge): state=IDLE, clear_pending=0, o_error=0, clear counter=0.
- Outputs during reset: o_ready=0, o_busy=0, o_vram_en=0, o_vram_we=0, addr=0, wdata=0.
- Reset asserted during READ/WRITE/CLEAR aborts the operation. en and we are gated by i_resetn, so no write is issued in the reset cycle. A partial read-modify-write is dropped. A partial clear leaves words beyond the last written address untouched.
- The display may read any word concurrently. Its read of a word in the same cycle as WRITE returns old data (read-first BRAM). This is acceptable tearing.

## Configuration
- VRAM_PIXEL_WRITER_CLEAR_EN defined:
  - An i_clear high at any edge outside CLEAR sets clear_pending. i_clear during CLEAR is ignored.
  - A pixel operation already in flight completes first.
  - In IDLE with clear_pending set, the next state is CLEAR and clear_pending clears.
  - CLEAR issues en=1, we=1, wdata=0, addr=0..4799, one word per cycle, then returns to IDLE. o_ready is low throughout: 4800 cycles plus 1 cycle of entry.
- Not defined: i_clear is ignored, the CLEAR state and its counter are not built, and clear_pending stays 0.

## Test plan
- VRAM zeroed; set (0,0) -> READ addr 0, then WRITE addr 0 with wdata 0x8000; o_ready returns 3 cycles after the transfer.
- Set (17,0) -> WRITE addr 1 with wdata 0x4000. Then set (16,0) -> wdata 0xC000.
- Toggle (319,239) twice -> addr 4799, wdata 0x0001 then 0x0000.
- Request (320,0) op 01 -> o_error=1 for exactly one cycle, o_vram_en never asserted, o_ready high again the next cycle.
- i_valid held high with 4 in-range requests -> exactly 4 transfers, at cycles 0, 3, 6 and 9, and 8 enabled VRAM cycles.
- With CLEAR_EN defined: i_clear pulsed during a WRITE -> the pixel write completes, then 4800 zero writes to addr 0..4799 follow. Reset at clear address 100 -> no write at that edge, state IDLE, o_ready=1 after release.
